fright_mode_sched: RTL
======================

FRIGHT_MODE_SCHED -- requirements
Module: fright_mode_sched

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 level_start  input  1  one-cycle pulse: (re)start scatter/chase schedule for current level.
REQ-004 level  input  5  current level, 1-21+.
REQ-005 fright_time  input  4  frightened duration, seconds, from level parameter block.
REQ-006 fright_flashes  input  3  flash count, from level parameter block.
REQ-007 frame_tick  input  1  one-cycle pulse, 60 Hz.
REQ-008 energizer_eaten  input  1  one-cycle pulse when Pac-Man eats an energizer.
REQ-009 pause  input  1  freezes all timers (death/intermission) while high.
REQ-010 chase_mode  output  1  0 = scatter, 1 = chase.
REQ-011 frightened  output  1  ghosts frightened.
REQ-012 fright_flash  output  1  frightened ghosts drawn white.
REQ-013 reverse_req  output  1  one-cycle pulse: ghosts reverse direction.
REQ-014 phase  output  3  schedule phase index 0-7; even = scatter, odd = chase.

Function
REQ-015 States: IDLE, RUN, FRIGHT; IDLE until level_start.
REQ-016 level_start (any state): phase=0, phase timer loaded from table, frightened=0, fright_flash=0, state RUN; no reverse_req.
REQ-017 Phase durations in frames, 16-bit. L1: 420,1200,420,1200,300,1200,300,inf. L2-4: 420,1200,420,1200,300,61980,1,inf. L5+: 300,1200,300,1200,300,62220,1,inf. Level 0 treated as L1.
REQ-018 RUN: each frame_tick with pause=0 decrements phase timer; on tick where timer=1, phase increments, next duration loads, reverse_req pulses next cycle.
REQ-019 Phase 7 never expires; timer held.
REQ-020 energizer_eaten in RUN or FRIGHT: reverse_req pulse; if fright_time>0 load fright counter = fright_time*60 (10 bits) and enter/stay FRIGHT; if fright_time=0 stay RUN, frightened stays 0.
REQ-021 FRIGHT: phase timer frozen; frame_tick with pause=0 decrements fright counter; counter=1 at tick: return to RUN, frightened=0, fright_flash=0, no reverse_req.
REQ-022 Flash window W = fright_flashes*28 frames. fright_flash=1 from first frame with counter<=W, toggles every 14 ticks, white first; W>=load value: flashing from entry; W=0: never flashes.
REQ-023 Energizer during FRIGHT restarts counter, fright_flash=0 unless new counter<=W.
REQ-024 Priority same cycle: rst > level_start > energizer_eaten > frame_tick; tick coinciding with energizer not counted.
REQ-025 pause=1: ticks ignored, outputs held; energizer_eaten still honoured.
REQ-026 chase_mode = phase[0]; outputs registered, update one cycle after cause.
REQ-027 level/fright inputs sampled only at load events; mid-phase changes do not affect running counters.

Reset
REQ-028 rst: state IDLE, phase=0, chase_mode=0, frightened=0, fright_flash=0, reverse_req=0, all counters 0.
REQ-029 rst mid-FRIGHT aborts fright immediately; no reverse_req issued.

Structure
REQ-030 Shared package: state enum, phase duration table (3 level groups x 8), FRAMES_PER_SEC=60, FLASH_HALF=14, PHASE_INF marker.
REQ-031 One sub-module natural: fright_flash_timer (fright counter, window compare, 14-frame toggle).

Verification
REQ-032 L1, level_start, 420 ticks -> phase 0->1, chase_mode=1, one reverse_req; 1200 further ticks -> phase 2.
REQ-033 L1, fright_time=6, flashes=5, energizer in phase 1 -> reverse_req, frightened 360 ticks; fright_flash first at counter 140, toggles every 14; phase timer resumes unchanged.
REQ-034 fright_time=1, flashes=3 -> flashing from entry (84>=60), frightened ends after 60 ticks.
REQ-035 fright_time=0, energizer -> reverse_req only, frightened stays 0, schedule uninterrupted.
REQ-036 L5, advance to phase 6 (1 frame) -> phase 7 after one tick, two reverse_req pulses across phases 5->6->7, phase 7 holds indefinitely.
REQ-037 Energizer with frame_tick same cycle, then rst mid-FRIGHT -> tick not counted; after rst all outputs 0, state IDLE.

Source files
------------

// File: rtl/fright_mode_sched_pkg.sv
// Shared types and constants for the ghost scatter/chase/frightened scheduler.
// Phase durations are in 60 Hz frames; phase 7 never expires.
package fright_mode_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FRIGHT = 2'd2
    } state_e;

    localparam int FRAMES_PER_SEC = 60;
    localparam int FLASH_HALF     = 14;
    localparam logic [15:0] PHASE_INF = 16'hFFFF;

    // Rows: level group (L1, L2-4, L5+); columns: phase 0..7.
    localparam logic [0:2][0:7][15:0] PHASE_TBL = {
        16'd420, 16'd1200, 16'd420, 16'd1200, 16'd300, 16'd1200,  16'd300, PHASE_INF,
        16'd420, 16'd1200, 16'd420, 16'd1200, 16'd300, 16'd61980, 16'd1,   PHASE_INF,
        16'd300, 16'd1200, 16'd300, 16'd1200, 16'd300, 16'd62220, 16'd1,   PHASE_INF
    };

    function automatic logic [1:0] level_group(input logic [4:0] lvl);
        if (lvl <= 5'd1)      return 2'd0;
        else if (lvl <= 5'd4) return 2'd1;
        else                  return 2'd2;
    endfunction

    function automatic logic [15:0] phase_dur(input logic [1:0] grp, input logic [2:0] ph);
        return PHASE_TBL[grp][ph];
    endfunction

endpackage

// File: rtl/fright_mode_sched_if.sv
// Game-controller side bundle for the scheduler: frame/level events in, ghost mode out.
interface fright_mode_sched_if;
    logic       level_start;
    logic [4:0] level;
    logic [3:0] fright_time;
    logic [2:0] fright_flashes;
    logic       frame_tick;
    logic       energizer_eaten;
    logic       pause;
    logic       chase_mode;
    logic       frightened;
    logic       fright_flash;
    logic       reverse_req;
    logic [2:0] phase;

    modport master (
        output level_start, level, fright_time, fright_flashes,
               frame_tick, energizer_eaten, pause,
        input  chase_mode, frightened, fright_flash, reverse_req, phase
    );

    modport slave (
        input  level_start, level, fright_time, fright_flashes,
               frame_tick, energizer_eaten, pause,
        output chase_mode, frightened, fright_flash, reverse_req, phase
    );
endinterface

// File: rtl/fright_mode_sched_flash_timer.sv
// Frightened-duration down-counter with the end-of-fright white/blue flash window.
// Flash starts white on entry to the window and toggles every FLASH_HALF counted ticks.
module fright_flash_timer
    import fright_mode_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       tick,
    input  logic [3:0] secs,
    input  logic [2:0] flashes,
    output logic       fright_flash,
    output logic       expire
);

    logic [9:0] cnt_q, cnt_d;
    logic [7:0] win_q, win_d;
    logic [3:0] half_q, half_d;
    logic       flash_q, flash_d;
    logic [9:0] ld_val;
    logic [7:0] ld_win;

    always_comb begin
        cnt_d   = cnt_q;
        win_d   = win_q;
        half_d  = half_q;
        flash_d = flash_q;
        ld_val  = 10'(secs) * 10'(FRAMES_PER_SEC);
        ld_win  = 8'(flashes) * 8'(2 * FLASH_HALF);
        expire  = tick && (cnt_q == 10'd1);

        if (clr) begin
            cnt_d   = '0;
            win_d   = '0;
            half_d  = '0;
            flash_d = 1'b0;
        end else if (load) begin
            cnt_d = ld_val;
            win_d = ld_win;
            if (ld_val <= {2'b00, ld_win}) begin
                flash_d = 1'b1;
                half_d  = 4'(FLASH_HALF);
            end else begin
                flash_d = 1'b0;
                half_d  = '0;
            end
        end else if (tick) begin
            if (cnt_q == 10'd1) begin
                cnt_d   = '0;
                half_d  = '0;
                flash_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 10'd1;
                if (cnt_q <= {2'b00, win_q}) begin
                    // Already inside the window: count out the current half-period.
                    if (half_q == 4'd1) begin
                        flash_d = ~flash_q;
                        half_d  = 4'(FLASH_HALF);
                    end else begin
                        half_d = half_q - 4'd1;
                    end
                end else if (cnt_d <= {2'b00, win_q}) begin
                    flash_d = 1'b1;
                    half_d  = 4'(FLASH_HALF);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            win_q   <= '0;
            half_q  <= '0;
            flash_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            half_q  <= half_d;
            flash_q <= flash_d;
        end
    end

    assign fright_flash = flash_q;

endmodule

// File: rtl/fright_mode_sched.sv
// Ghost scatter/chase phase scheduler with energizer-driven frightened mode.
//   state     | meaning
//   ST_IDLE   | after reset, waiting for level_start
//   ST_RUN    | scatter/chase phase timer counting frame ticks
//   ST_FRIGHT | frightened; phase timer frozen, fright timer counting
module fright_mode_sched
    import fright_mode_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fright_mode_sched_if.slave   bus
);

    state_e      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic [15:0] ptmr_q, ptmr_d;
    logic [1:0]  grp_q, grp_d;
    logic        rev_q, rev_d;
    logic        fr_clr, fr_load, fr_tick, fr_expire, fr_flash;
    logic        tick_ok;

    assign tick_ok = bus.frame_tick && !bus.pause;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ptmr_d  = ptmr_q;
        grp_d   = grp_q;
        rev_d   = 1'b0;
        fr_clr  = 1'b0;
        fr_load = 1'b0;
        fr_tick = 1'b0;

        if (bus.level_start) begin
            state_d = ST_RUN;
            phase_d = 3'd0;
            grp_d   = level_group(bus.level);
            ptmr_d  = phase_dur(level_group(bus.level), 3'd0);
            fr_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.energizer_eaten) begin
                        rev_d = 1'b1;
                        if (bus.fright_time != 4'd0) begin
                            fr_load = 1'b1;
                            state_d = ST_FRIGHT;
                        end
                    end else if (tick_ok && phase_q != 3'd7) begin
                        if (ptmr_q == 16'd1) begin
                            phase_d = phase_q + 3'd1;
                            ptmr_d  = phase_dur(grp_q, phase_q + 3'd1);
                            rev_d   = 1'b1;
                        end else begin
                            ptmr_d = ptmr_q - 16'd1;
                        end
                    end
                end
                ST_FRIGHT: begin
                    if (bus.energizer_eaten) begin
                        rev_d   = 1'b1;
                        fr_load = (bus.fright_time != 4'd0);
                    end else if (tick_ok) begin
                        fr_tick = 1'b1;
                        if (fr_expire) state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            ptmr_q  <= '0;
            grp_q   <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ptmr_q  <= ptmr_d;
            grp_q   <= grp_d;
            rev_q   <= rev_d;
        end
    end

    fright_flash_timer u_flash (
        .clk          (clk),
        .rst          (rst),
        .clr          (fr_clr),
        .load         (fr_load),
        .tick         (fr_tick),
        .secs         (bus.fright_time),
        .flashes      (bus.fright_flashes),
        .fright_flash (fr_flash),
        .expire       (fr_expire)
    );

    assign bus.chase_mode   = phase_q[0];
    assign bus.phase        = phase_q;
    assign bus.frightened   = (state_q == ST_FRIGHT);
    assign bus.fright_flash = fr_flash;
    assign bus.reverse_req  = rev_q;

endmodule
